pid_pipe_param: RTL and testbench

//  Parametrised, 3-stage pipelined PID steering controller; successor to the single-cycle PID.

---
 rtl/pid_pipe_param.sv | 238 +++++++++++++++++++++++
 tb/tb_pid_pipe_param.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_pipe_param.sv
// -----------------------------------------------------------------------------
// pid_pipe_param
//   Three-stage pipelined PID steering controller. Saturated heading error
//   samples qualified by err_vld are turned into left/right motor speed
//   commands. spd_vld pulses three cycles after the accepting err_vld.
//
//   Stage 1 (sample edge) : error saturation, integrator update with
//                           anti-windup, D history shift, D difference.
//   Stage 2               : P, I and D terms registered at full product width.
//   Stage 3               : PID sum, scaling, speed mixing, two-sided clamp.
//
// Ports
//   clk       in   1        system clock, rising edge
//   rst_n     in   1        asynchronous active-low reset
//   moving    in   1        0: clear integrator, zero speeds, flush the pipe
//   err_vld   in   1        error sample valid, one-cycle qualifier
//   error     in   ERR_W    signed heading error
//   frwrd     in   FRWRD_W  unsigned forward speed, sampled with err_vld
//   lft_spd   out  SPD_W    signed left speed, registered
//   rght_spd  out  SPD_W    signed right speed, registered
//   spd_vld   out  1        one-cycle pulse when lft_spd/rght_spd update
// -----------------------------------------------------------------------------
module pid_pipe_param #(
    parameter int        ERR_W     = 12,
    parameter int        SAT_W     = 10,
    parameter int        INT_W     = 15,
    parameter int        I_SHIFT   = 6,
    parameter int        D_SAT_W   = 7,
    parameter int        D_DEPTH   = 2,
    parameter int signed P_COEFF   = 8,
    parameter int signed D_COEFF   = 11,
    parameter int        SUM_SHIFT = 3,
    parameter int        FRWRD_W   = 10,
    parameter int        SPD_W     = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      moving,
    input  logic                      err_vld,
    input  logic signed [ERR_W-1:0]   error,
    input  logic        [FRWRD_W-1:0] frwrd,
    output logic signed [SPD_W-1:0]   lft_spd,
    output logic signed [SPD_W-1:0]   rght_spd,
    output logic                      spd_vld
);

    // Gains are carried as CW-bit signed constants; product widths are sized
    // so no multiplication or sum can overflow.
    localparam int CW    = 16;
    localparam int P_W   = SAT_W + CW;
    localparam int D_W   = D_SAT_W + CW;
    localparam int DIF_W = SAT_W + 1;
    localparam int PD_W  = (P_W > D_W) ? P_W : D_W;
    localparam int PID_W = ((PD_W > INT_W) ? PD_W : INT_W) + 2;
    localparam int MIX_W = ((PID_W > FRWRD_W + 1) ? PID_W : FRWRD_W + 1) + 1;

    localparam logic signed [CW-1:0] P_K = CW'(P_COEFF);
    localparam logic signed [CW-1:0] D_K = CW'(D_COEFF);

    localparam logic signed [ERR_W-1:0] ERR_HI = ERR_W'((32'sd1 <<< (SAT_W - 1)) - 32'sd1);
    localparam logic signed [ERR_W-1:0] ERR_LO = ERR_W'(-(32'sd1 <<< (SAT_W - 1)));
    localparam logic signed [DIF_W-1:0] DIF_HI = DIF_W'((32'sd1 <<< (D_SAT_W - 1)) - 32'sd1);
    localparam logic signed [DIF_W-1:0] DIF_LO = DIF_W'(-(32'sd1 <<< (D_SAT_W - 1)));
    localparam logic signed [MIX_W-1:0] SPD_HI = MIX_W'((32'sd1 <<< (SPD_W - 1)) - 32'sd1);
    localparam logic signed [MIX_W-1:0] SPD_LO = MIX_W'(-(32'sd1 <<< (SPD_W - 1)));

    // Clamp the raw error into the SAT_W signed range.
    function automatic logic signed [SAT_W-1:0] sat_err(input logic signed [ERR_W-1:0] v);
        logic signed [SAT_W-1:0] r;
        if (v > ERR_HI) begin
            r = ERR_HI[SAT_W-1:0];
        end else if (v < ERR_LO) begin
            r = ERR_LO[SAT_W-1:0];
        end else begin
            r = v[SAT_W-1:0];
        end
        return r;
    endfunction

    // Clamp the D difference into the D_SAT_W signed range.
    function automatic logic signed [D_SAT_W-1:0] sat_dif(input logic signed [DIF_W-1:0] v);
        logic signed [D_SAT_W-1:0] r;
        if (v > DIF_HI) begin
            r = DIF_HI[D_SAT_W-1:0];
        end else if (v < DIF_LO) begin
            r = DIF_LO[D_SAT_W-1:0];
        end else begin
            r = v[D_SAT_W-1:0];
        end
        return r;
    endfunction

    // Clamp a mixed speed into the SPD_W signed range.
    function automatic logic signed [SPD_W-1:0] sat_spd(input logic signed [MIX_W-1:0] v);
        logic signed [SPD_W-1:0] r;
        if (v > SPD_HI) begin
            r = SPD_HI[SPD_W-1:0];
        end else if (v < SPD_LO) begin
            r = SPD_LO[SPD_W-1:0];
        end else begin
            r = v[SPD_W-1:0];
        end
        return r;
    endfunction

    // Stage 1 state
    logic signed [INT_W-1:0]   integ_r;
    logic signed [SAT_W-1:0]   hist_r [D_DEPTH];
    logic                      s1_vld_r;
    logic signed [SAT_W-1:0]   s1_err_r;
    logic signed [D_SAT_W-1:0] s1_dif_r;
    logic signed [INT_W-1:0]   s1_integ_r;
    logic        [FRWRD_W-1:0] s1_frwrd_r;

    // Stage 2 state
    logic                      s2_vld_r;
    logic signed [P_W-1:0]     s2_p_r;
    logic signed [INT_W-1:0]   s2_i_r;
    logic signed [D_W-1:0]     s2_d_r;
    logic        [FRWRD_W-1:0] s2_frwrd_r;

    // Combinational helpers
    logic signed [SAT_W-1:0]   err_sat_s;
    logic signed [DIF_W-1:0]   dif_s;
    logic signed [D_SAT_W-1:0] dif_sat_s;
    logic signed [INT_W-1:0]   integ_sum_s;
    logic                      integ_ovf_s;
    logic signed [INT_W-1:0]   integ_upd_s;
    logic signed [PID_W-1:0]   pid_s;
    logic signed [PID_W-1:0]   mix_m_s;
    logic signed [MIX_W-1:0]   lft_mix_s;
    logic signed [MIX_W-1:0]   rght_mix_s;

    // Stage 1 arithmetic: saturation, D difference and integrator with anti-windup.
    always_comb begin
        err_sat_s   = sat_err(error);
        dif_s       = DIF_W'(err_sat_s) - DIF_W'(hist_r[D_DEPTH-1]);
        dif_sat_s   = sat_dif(dif_s);
        integ_sum_s = integ_r + INT_W'(err_sat_s);
        // Overflow only when both operands share a sign the sum does not.
        integ_ovf_s = (integ_r[INT_W-1] == err_sat_s[SAT_W-1]) &&
                      (integ_sum_s[INT_W-1] != integ_r[INT_W-1]);
        if (integ_ovf_s) begin
            integ_upd_s = integ_r;
        end else begin
            integ_upd_s = integ_sum_s;
        end
    end

    // Stage 1 registers: integrator, D history and sample capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ_r    <= '0;
            s1_vld_r   <= 1'b0;
            s1_err_r   <= '0;
            s1_dif_r   <= '0;
            s1_integ_r <= '0;
            s1_frwrd_r <= '0;
            for (int i = 0; i < D_DEPTH; i++) begin
                hist_r[i] <= '0;
            end
        end else if (!moving) begin
            // Flush: integrator cleared, D history deliberately kept.
            integ_r  <= '0;
            s1_vld_r <= 1'b0;
        end else begin
            s1_vld_r <= err_vld;
            if (err_vld) begin
                integ_r    <= integ_upd_s;
                s1_err_r   <= err_sat_s;
                s1_dif_r   <= dif_sat_s;
                // The I term of this sample uses the integrator including it.
                s1_integ_r <= integ_upd_s;
                s1_frwrd_r <= frwrd;
                hist_r[0]  <= err_sat_s;
                for (int i = 1; i < D_DEPTH; i++) begin
                    hist_r[i] <= hist_r[i-1];
                end
            end else begin
                integ_r <= integ_r;
            end
        end
    end

    // Stage 2 registers: P, I and D terms at full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_r   <= 1'b0;
            s2_p_r     <= '0;
            s2_i_r     <= '0;
            s2_d_r     <= '0;
            s2_frwrd_r <= '0;
        end else if (!moving) begin
            s2_vld_r <= 1'b0;
        end else begin
            s2_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
                s2_p_r     <= P_W'(s1_err_r) * P_W'(P_K);
                s2_i_r     <= s1_integ_r >>> I_SHIFT;
                s2_d_r     <= D_W'(s1_dif_r) * D_W'(D_K);
                s2_frwrd_r <= s1_frwrd_r;
            end else begin
                s2_frwrd_r <= s2_frwrd_r;
            end
        end
    end

    // Stage 3 arithmetic: PID sum, scaling and left/right mixing.
    always_comb begin
        pid_s      = PID_W'(s2_p_r) + PID_W'(s2_i_r) + PID_W'(s2_d_r);
        mix_m_s    = pid_s >>> SUM_SHIFT;
        lft_mix_s  = MIX_W'({1'b0, s2_frwrd_r}) + MIX_W'(mix_m_s);
        rght_mix_s = MIX_W'({1'b0, s2_frwrd_r}) - MIX_W'(mix_m_s);
    end

    // Stage 3 registers: clamped speed outputs and valid pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else if (!moving) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            spd_vld  <= 1'b0;
        end else begin
            spd_vld <= s2_vld_r;
            if (s2_vld_r) begin
                lft_spd  <= sat_spd(lft_mix_s);
                rght_spd <= sat_spd(rght_mix_s);
            end else begin
                lft_spd  <= lft_spd;
                rght_spd <= rght_spd;
            end
        end
    end

endmodule

// File: tb/tb_pid_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_pid_pipe_param
//   Directed and randomized stimulus for pid_pipe_param at default
//   parameters. A behavioural model computes each accepted sample's speeds
//   with plain integer arithmetic and queues them with the cycle they are due.
// -----------------------------------------------------------------------------
module tb_pid_pipe_param;

    localparam int ERR_W     = 12;
    localparam int SAT_W     = 10;
    localparam int INT_W     = 15;
    localparam int I_SHIFT   = 6;
    localparam int D_SAT_W   = 7;
    localparam int D_DEPTH   = 2;
    localparam int P_COEFF   = 8;
    localparam int D_COEFF   = 11;
    localparam int SUM_SHIFT = 3;
    localparam int FRWRD_W   = 10;
    localparam int SPD_W     = 11;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      moving;
    logic                      err_vld;
    logic        [ERR_W-1:0]   error;
    logic        [FRWRD_W-1:0] frwrd;
    logic signed [SPD_W-1:0]   lft_spd;
    logic signed [SPD_W-1:0]   rght_spd;
    logic                      spd_vld;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int due;
        int l;
        int r;
    } ent_t;

    int   m_integ;
    int   m_hist [D_DEPTH];
    ent_t m_q [$];
    logic exp_v;
    int   exp_l;
    int   exp_r;

    pid_pipe_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .moving   (moving),
        .err_vld  (err_vld),
        .error    (error),
        .frwrd    (frwrd),
        .lft_spd  (lft_spd),
        .rght_spd (rght_spd),
        .spd_vld  (spd_vld)
    );

    always #5 clk = ~clk;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_clear();
        m_integ = 0;
        for (int k = 0; k < D_DEPTH; k++) m_hist[k] = 0;
        m_q.delete();
        exp_v = 1'b0;
        exp_l = 0;
        exp_r = 0;
    endtask

    // Compute the outputs of one accepted sample straight from the rules.
    task automatic model_accept(input int e, input int fw);
        int es, dd, s, p, i, d, pid, m;
        ent_t ent;
        es = clamp(e, -(2 ** (SAT_W - 1)), 2 ** (SAT_W - 1) - 1);
        dd = clamp(es - m_hist[D_DEPTH-1], -(2 ** (D_SAT_W - 1)), 2 ** (D_SAT_W - 1) - 1);
        for (int k = D_DEPTH - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = es;
        s = m_integ + es;
        if (s >= -(2 ** (INT_W - 1)) && s <= 2 ** (INT_W - 1) - 1) m_integ = s;
        p   = P_COEFF * es;
        i   = m_integ >>> I_SHIFT;
        d   = D_COEFF * dd;
        pid = p + i + d;
        m   = pid >>> SUM_SHIFT;
        ent.due = cyc + 2;
        ent.l   = clamp(fw + m, -(2 ** (SPD_W - 1)), 2 ** (SPD_W - 1) - 1);
        ent.r   = clamp(fw - m, -(2 ** (SPD_W - 1)), 2 ** (SPD_W - 1) - 1);
        m_q.push_back(ent);
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (spd_vld === exp_v) else begin
            failures++;
            $error("FAIL %s.spd_vld cyc=%0d got=%0b exp=%0b", tag, cyc, spd_vld, exp_v);
        end
        checks++;
        assert (lft_spd === SPD_W'(exp_l)) else begin
            failures++;
            $error("FAIL %s.lft_spd cyc=%0d got=%0d exp=%0d", tag, cyc, lft_spd, exp_l);
        end
        checks++;
        assert (rght_spd === SPD_W'(exp_r)) else begin
            failures++;
            $error("FAIL %s.rght_spd cyc=%0d got=%0d exp=%0d", tag, cyc, rght_spd, exp_r);
        end
    endtask

    task automatic check_const(input string tag, input logic [SPD_W-1:0] l, input logic [SPD_W-1:0] r);
        checks++;
        assert (spd_vld === 1'b1) else begin
            failures++;
            $error("FAIL %s.vld got=%0b exp=1", tag, spd_vld);
        end
        checks++;
        assert (lft_spd === l) else begin
            failures++;
            $error("FAIL %s.lft got=%h exp=%h", tag, lft_spd, l);
        end
        checks++;
        assert (rght_spd === r) else begin
            failures++;
            $error("FAIL %s.rght got=%h exp=%h", tag, rght_spd, r);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic v, input logic [ERR_W-1:0] e, input int fw, input logic mov);
        err_vld = v;
        error   = e;
        frwrd   = FRWRD_W'(fw);
        moving  = mov;
        @(posedge clk);
        cyc++;
        if (!mov) begin
            m_integ = 0;
            m_q.delete();
            exp_v = 1'b0;
            exp_l = 0;
            exp_r = 0;
        end else begin
            if (v) model_accept(int'($signed(e)), fw);
            exp_v = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == cyc) begin
                exp_v = 1'b1;
                exp_l = m_q[0].l;
                exp_r = m_q[0].r;
                void'(m_q.pop_front());
            end
        end
        #1;
        check_outputs("step");
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 0, 1'b1);
    endtask

    // Asynchronous reset pulse asserted mid-cycle, away from the clock edge.
    task automatic do_reset();
        #2;
        err_vld = 1'b0;
        rst_n   = 1'b0;
        #1;
        model_clear();
        check_outputs("rst");
        @(posedge clk);
        cyc++;
        #1;
        check_outputs("rst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        moving  = 1'b1;
        err_vld = 1'b0;
        error   = '0;
        frwrd   = '0;
        model_clear();
        @(posedge clk);
        #1;
        do_reset();

        // Single sample from reset
        step(1'b1, 12'h010, 'h100, 1'b1);
        idle(2);
        check_const("t1", 11'h126, 11'h0DA);
        idle(2);

        // Three back-to-back samples
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 12'h010, 'h100, 1'b1);
        idle(3);

        // Error and D difference saturation, left speed clamp
        do_reset();
        step(1'b1, 12'h7FF, 'h3FF, 1'b1);
        idle(2);
        check_const("t3", 11'h3FF, 11'h1A9);

        // Integrator anti-windup
        do_reset();
        for (int k = 0; k < 40; k++) step(1'b1, 12'h1FF, 0, 1'b1);
        idle(2);
        check_const("t4", 11'h21E, 11'h5E2);

        // Negative saturation
        do_reset();
        step(1'b1, 12'h800, 0, 1'b1);
        idle(2);
        check_const("t5", 11'h5A7, 11'h259);

        // Flush by moving=0 with samples in flight; history survives
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 12'h1FF, 'h100, 1'b1);
        step(1'b1, 12'h010, 'h100, 1'b0);
        idle(4);
        step(1'b1, 12'h010, 'h100, 1'b1);
        idle(2);
        check_const("t6_mov", 11'h0B8, 11'h148);

        // Flush by reset with samples in flight; history cleared
        for (int k = 0; k < 2; k++) step(1'b1, 12'h1FF, 'h100, 1'b1);
        do_reset();
        idle(4);
        step(1'b1, 12'h010, 'h100, 1'b1);
        idle(2);
        check_const("t6_rst", 11'h126, 11'h0DA);

        // Randomized traffic with occasional moving drops and resets
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [ERR_W-1:0] e;
            logic             v;
            logic             mv;
            if ($urandom_range(0, 1) == 1) e = ERR_W'($urandom);
            else e = ERR_W'($urandom_range(0, 1200) - 600);
            v  = ($urandom_range(0, 3) != 0);
            mv = ($urandom_range(0, 19) != 0);
            step(v, e, int'($urandom_range(0, 1023)), mv);
            if ($urandom_range(0, 149) == 0) do_reset();
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
